inst_fetcher: RTL and testbench

- Instruction-fetch requester for the memory controller's IF port. It is the initiator that drives `if_read_or_not`/`intru_addr` and consumes `if_load_done`/`mem_ctrl_instru_to_if`.
- Holds the PC and a direct-mapped instruction cache.
- Presents one instruction at a time to decode through a valid/ready slot. Redirects on jump.

---
 rtl/inst_fetcher.sv | 154 +++++++++++++++
 tb/tb_inst_fetcher.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Instruction fetch unit: PC, 16-entry direct-mapped I-cache and a single
// valid/ready output slot, requesting misses from the memory controller.
module inst_fetcher #(
  parameter int          INDEX_WIDTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_load_done,
  input  logic [31:0] mem_ctrl_instru_to_if,
  output logic        if_read_or_not,
  output logic [31:0] intru_addr,
  input  logic        decode_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        jump_flag,
  input  logic [31:0] jump_target
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_W   = 32 - INDEX_WIDTH - 2;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t                   r_state;
  logic [31:0]              r_pc;
  logic                     r_req;
  logic [31:0]              r_addr;
  logic                     r_inst_valid;
  logic [31:0]              r_inst;
  logic [31:0]              r_inst_pc;
  logic [ENTRIES-1:0]       r_valid;
  logic [TAG_W-1:0]         r_tag  [ENTRIES];
  logic [31:0]              r_data [ENTRIES];

  state_t                   w_state_nxt;
  logic [31:0]              w_pc_nxt;
  logic                     w_req_nxt;
  logic [31:0]              w_addr_nxt;
  logic                     w_inst_valid_nxt;
  logic [31:0]              w_inst_nxt;
  logic [31:0]              w_inst_pc_nxt;

  logic [INDEX_WIDTH-1:0]   w_idx;
  logic [TAG_W-1:0]         w_tag;
  logic                     w_hit;
  logic                     w_slot_free;
  logic                     w_fill;
  logic [INDEX_WIDTH-1:0]   w_fill_idx;
  logic [TAG_W-1:0]         w_fill_tag;

  assign w_idx       = r_pc[INDEX_WIDTH+1:2];
  assign w_tag       = r_pc[31:INDEX_WIDTH+2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_slot_free = !r_inst_valid || decode_ready;

  // A completion only counts while a request is outstanding; the fill
  // proceeds even when a jump arrives in the same cycle.
  assign w_fill      = (r_state == WAIT_MEM) && if_load_done;
  assign w_fill_idx  = r_addr[INDEX_WIDTH+1:2];
  assign w_fill_tag  = r_addr[31:INDEX_WIDTH+2];

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_nxt        = r_req;
    w_addr_nxt       = r_addr;
    w_inst_valid_nxt = r_inst_valid;
    w_inst_nxt       = r_inst;
    w_inst_pc_nxt    = r_inst_pc;

    if (r_inst_valid && decode_ready) begin
      w_inst_valid_nxt = 1'b0;
    end

    if (jump_flag) begin
      w_pc_nxt         = jump_target;
      w_inst_valid_nxt = 1'b0;
      w_state_nxt      = IDLE;
      w_req_nxt        = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_slot_free) begin
            if (w_hit) begin
              w_inst_nxt       = r_data[w_idx];
              w_inst_pc_nxt    = r_pc;
              w_inst_valid_nxt = 1'b1;
              w_pc_nxt         = r_pc + 32'd4;
            end else begin
              w_req_nxt   = 1'b1;
              w_addr_nxt  = r_pc;
              w_state_nxt = WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          // Address stays put while waiting: memctrl restarts on any change.
          if (if_load_done) begin
            w_req_nxt   = 1'b0;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_addr       <= 32'h0;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'h0;
      r_inst_pc    <= 32'h0;
      r_valid      <= '0;
    end else if (rdy_in) begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req        <= w_req_nxt;
      r_addr       <= w_addr_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      if (w_fill) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage are qualified by r_valid, so they need no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rst_in && w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_ctrl_instru_to_if;
    end
  end

  assign if_read_or_not = r_req;
  assign intru_addr     = r_addr;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: drives a hand-sequenced memctrl and
// decode, comparing outputs against hand-computed values.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_load_done;
  logic [31:0] mem_ctrl_instru_to_if;
  logic        if_read_or_not;
  logic [31:0] intru_addr;
  logic        decode_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        jump_flag;
  logic [31:0] jump_target;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] W0   = 32'h0000_0513;
  localparam logic [31:0] W4   = 32'h1000_0004;
  localparam logic [31:0] W8   = 32'h1000_0008;
  localparam logic [31:0] WC   = 32'h1000_000C;
  localparam logic [31:0] W100 = 32'h2000_0100;

  inst_fetcher #(.INDEX_WIDTH(4), .RESET_PC(32'h0)) dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .rdy_in                (rdy_in),
    .if_load_done          (if_load_done),
    .mem_ctrl_instru_to_if (mem_ctrl_instru_to_if),
    .if_read_or_not        (if_read_or_not),
    .intru_addr            (intru_addr),
    .decode_ready          (decode_ready),
    .inst_valid            (inst_valid),
    .inst                  (inst),
    .inst_pc               (inst_pc),
    .jump_flag             (jump_flag),
    .jump_target           (jump_target)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!if_read_or_not && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, {31'h0, if_read_or_not}, 32'h1);
  endtask

  // Act as memctrl: expect a request at addr, hold for dly cycles, return word.
  task automatic serve(input string tag, input logic [31:0] addr,
                       input logic [31:0] word, input int dly);
    wait_req(tag);
    chk({tag, "_addr"}, intru_addr, addr);
    repeat (dly) tick();
    chk({tag, "_addr_held"}, intru_addr, addr);
    if_load_done          = 1'b1;
    mem_ctrl_instru_to_if = word;
    tick();
    if_load_done          = 1'b0;
    mem_ctrl_instru_to_if = 32'h0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; if_load_done = 1'b0;
    mem_ctrl_instru_to_if = 32'h0; decode_ready = 1'b0;
    jump_flag = 1'b0; jump_target = 32'h0;

    // Test 1: reset state, then first request
    tick();
    tick();
    rst_in = 1'b0;
    chk("rst_req",   {31'h0, if_read_or_not}, 32'h0);
    chk("rst_addr",  intru_addr, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst",  inst, 32'h0);
    chk("rst_pc",    inst_pc, 32'h0);
    tick();
    chk("t1_req",  {31'h0, if_read_or_not}, 32'h1);
    chk("t1_addr", intru_addr, 32'h0);

    // Test 2: miss at 0x0, completion after 6 cycles
    decode_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_req",  {31'h0, if_read_or_not}, 32'h1);
      chk("t2_hold_addr", intru_addr, 32'h0);
    end
    if_load_done = 1'b1; mem_ctrl_instru_to_if = W0;
    tick();
    if_load_done = 1'b0; mem_ctrl_instru_to_if = 32'h0;
    chk("t2_req_drop", {31'h0, if_read_or_not}, 32'h0);
    chk("t2_not_yet",  {31'h0, inst_valid}, 32'h0);
    tick();
    chk("t2_valid", {31'h0, inst_valid}, 32'h1);
    chk("t2_inst",  inst, W0);
    chk("t2_pc",    inst_pc, 32'h0);
    tick();
    chk("t2_next_req",  {31'h0, if_read_or_not}, 32'h1);
    chk("t2_next_addr", intru_addr, 32'h4);
    chk("t2_consumed",  {31'h0, inst_valid}, 32'h0);

    // Test 3: fill 0x4..0xC, jump to 0x0, stream four hits
    serve("f4", 32'h4, W4, 2);
    serve("f8", 32'h8, W8, 1);
    serve("fC", 32'hC, WC, 1);
    jump_flag = 1'b1; jump_target = 32'h0;
    tick();
    jump_flag = 1'b0;
    chk("t3_jump_req", {31'h0, if_read_or_not}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_valid", {31'h0, inst_valid}, 32'h1);
      chk("t3_pc",    inst_pc, 32'(i * 4));
      chk("t3_noreq", {31'h0, if_read_or_not}, 32'h0);
    end
    chk("t3_inst_c", inst, WC);
    tick();
    chk("t3_req10",  {31'h0, if_read_or_not}, 32'h1);
    chk("t3_addr10", intru_addr, 32'h10);

    // Test 4: decode stall with a full slot
    decode_ready = 1'b0;
    jump_flag = 1'b1; jump_target = 32'h0;
    tick();
    jump_flag = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_valid", {31'h0, inst_valid}, 32'h1);
      chk("t4_pc",    inst_pc, 32'h0);
      chk("t4_inst",  inst, W0);
      chk("t4_noreq", {31'h0, if_read_or_not}, 32'h0);
    end
    decode_ready = 1'b1;
    tick();
    chk("t4_resume_pc",   inst_pc, 32'h4);
    chk("t4_resume_inst", inst, W4);

    // Test 5: jump away while waiting at 0x8, late completion ignored
    do_reset();
    serve("r0", 32'h0, W0, 1);
    serve("r4", 32'h4, W4, 1);
    wait_req("t5");
    chk("t5_addr8", intru_addr, 32'h8);
    jump_flag = 1'b1; jump_target = 32'h100;
    tick();
    jump_flag = 1'b0;
    chk("t5_req_drop", {31'h0, if_read_or_not}, 32'h0);
    if_load_done = 1'b1; mem_ctrl_instru_to_if = 32'hDEAD_BEEF;
    tick();
    if_load_done = 1'b0; mem_ctrl_instru_to_if = 32'h0;
    chk("t5_req_100",  {31'h0, if_read_or_not}, 32'h1);
    chk("t5_addr_100", intru_addr, 32'h100);
    chk("t5_no_valid", {31'h0, inst_valid}, 32'h0);
    serve("f100", 32'h100, W100, 1);
    tick();
    chk("t5_inst_100", inst, W100);
    chk("t5_pc_100",   inst_pc, 32'h100);
    jump_flag = 1'b1; jump_target = 32'h8;
    tick();
    jump_flag = 1'b0;
    tick();
    chk("t5_miss8_req",  {31'h0, if_read_or_not}, 32'h1);
    chk("t5_miss8_addr", intru_addr, 32'h8);
    chk("t5_miss8_vld",  {31'h0, inst_valid}, 32'h0);

    // Test 7: global stall while waiting, jump attempt must be frozen out
    rdy_in = 1'b0;
    jump_flag = 1'b1; jump_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_req",   {31'h0, if_read_or_not}, 32'h1);
      chk("t7_addr",  intru_addr, 32'h8);
      chk("t7_valid", {31'h0, inst_valid}, 32'h0);
      chk("t7_inst",  inst, W100);
      chk("t7_pc",    inst_pc, 32'h100);
    end
    rdy_in = 1'b1; jump_flag = 1'b0;
    serve("f8b", 32'h8, W8, 1);
    tick();
    chk("t7_inst8", inst, W8);
    chk("t7_pc8",   inst_pc, 32'h8);

    // Test 6: index conflict evicts 0x0
    do_reset();
    serve("e0", 32'h0, 32'h1111_1111, 1);
    tick();
    chk("t6_inst0", inst, 32'h1111_1111);
    jump_flag = 1'b1; jump_target = 32'h40;
    tick();
    jump_flag = 1'b0;
    serve("e40", 32'h40, 32'h2222_2222, 1);
    tick();
    chk("t6_inst40", inst, 32'h2222_2222);
    chk("t6_pc40",   inst_pc, 32'h40);
    jump_flag = 1'b1; jump_target = 32'h0;
    tick();
    jump_flag = 1'b0;
    tick();
    chk("t6_evict_req",  {31'h0, if_read_or_not}, 32'h1);
    chk("t6_evict_addr", intru_addr, 32'h0);
    chk("t6_evict_vld",  {31'h0, inst_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
